// File: rtl/usxgmii_width_gearbox_if.sv
// Bus bundle for usxgmii_width_gearbox: narrow USXGMII-side input word
// and the packed wide XGMII-side output word plus the pad counter.
// master: stream source / consumer side; slave: gearbox side.
interface usxgmii_width_gearbox_if #(
  parameter int unsigned p_in_bytes = 4,
  parameter int unsigned p_ratio    = 2
);
  logic                                i_usxgmii_valid;
  logic [p_in_bytes-1:0]               i_usxgmii_control;
  logic [8*p_in_bytes-1:0]             i_usxgmii_data;
  logic                                o_xgmii_valid;
  logic [p_in_bytes*p_ratio-1:0]       o_xgmii_control;
  logic [8*p_in_bytes*p_ratio-1:0]     o_xgmii_data;
  logic [15:0]                         o_pad_count;

  modport master (
    output i_usxgmii_valid, i_usxgmii_control, i_usxgmii_data,
    input  o_xgmii_valid, o_xgmii_control, o_xgmii_data, o_pad_count
  );

  modport slave (
    input  i_usxgmii_valid, i_usxgmii_control, i_usxgmii_data,
    output o_xgmii_valid, o_xgmii_control, o_xgmii_data, o_pad_count
  );
endinterface

// File: rtl/usxgmii_width_gearbox.sv
// USXGMII -> XGMII width gearbox: packs p_ratio accepted input words into
// one wide output word, lane 0 / slot 0 in the LSBs, 1-cycle latency.
// Optional start alignment (macro USXGMII_GEARBOX_START_ALIGN_EN): a start
// character landing in a non-zero slot closes the current word with Idle
// padding and restarts packing with the start word in slot 0.
module usxgmii_width_gearbox #(
  parameter int unsigned p_in_bytes = 4,
  parameter int unsigned p_ratio    = 2
) (
  input logic                    i_clock,
  input logic                    i_reset,
  usxgmii_width_gearbox_if.slave bus
);
  localparam int unsigned lane_w  = 8 * p_in_bytes;
  localparam int unsigned word_w  = lane_w * p_ratio;
  localparam int unsigned ctrl_w  = p_in_bytes * p_ratio;
  localparam int unsigned phase_w = (p_ratio > 2) ? 2 : 1;
  localparam logic [phase_w-1:0] last_phase = phase_w'(p_ratio - 1);
  localparam logic [lane_w-1:0]  idle_lane  = {p_in_bytes{8'h07}};
  localparam logic [word_w-1:0]  idle_word  = {ctrl_w{8'h07}};

  logic [phase_w-1:0] phase;
  logic [word_w-1:0]  acc_data;
  logic [ctrl_w-1:0]  acc_ctrl;
  logic               out_valid;
  logic [word_w-1:0]  out_data;
  logic [ctrl_w-1:0]  out_ctrl;
  logic [word_w-1:0]  merged_data;
  logic [ctrl_w-1:0]  merged_ctrl;

  // Partial word with the current input dropped into the slot at phase.
  always_comb begin
    merged_data = acc_data;
    merged_ctrl = acc_ctrl;
    for (int unsigned s = 0; s < p_ratio; s++) begin
      if (s == 32'(phase)) begin
        merged_data[s*lane_w +: lane_w]         = bus.i_usxgmii_data;
        merged_ctrl[s*p_in_bytes +: p_in_bytes] = bus.i_usxgmii_control;
      end
    end
  end

`ifdef USXGMII_GEARBOX_START_ALIGN_EN
  logic [15:0]       pad_count;
  logic              is_start;
  logic [word_w-1:0] pad_data;
  logic [ctrl_w-1:0] pad_ctrl;

  assign is_start = bus.i_usxgmii_control[0] && (bus.i_usxgmii_data[7:0] == 8'hFB);

  // Partial word with every slot from phase upward replaced by Idle.
  always_comb begin
    pad_data = acc_data;
    pad_ctrl = acc_ctrl;
    for (int unsigned s = 0; s < p_ratio; s++) begin
      if (s >= 32'(phase)) begin
        pad_data[s*lane_w +: lane_w]         = idle_lane;
        pad_ctrl[s*p_in_bytes +: p_in_bytes] = '1;
      end
    end
  end

  assign bus.o_pad_count = pad_count;
`else
  assign bus.o_pad_count = '0;
`endif

  // Slot sequencing, output word register and pad counter.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      phase     <= '0;
      acc_data  <= idle_word;
      acc_ctrl  <= '1;
      out_valid <= 1'b0;
      out_data  <= idle_word;
      out_ctrl  <= '1;
`ifdef USXGMII_GEARBOX_START_ALIGN_EN
      pad_count <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      if (bus.i_usxgmii_valid) begin
`ifdef USXGMII_GEARBOX_START_ALIGN_EN
        // Misaligned start takes priority; otherwise fall into normal packing.
        if (is_start && phase != '0) begin
          out_valid              <= 1'b1;
          out_data               <= pad_data;
          out_ctrl               <= pad_ctrl;
          acc_data[lane_w-1:0]   <= bus.i_usxgmii_data;
          acc_ctrl[p_in_bytes-1:0] <= bus.i_usxgmii_control;
          phase                  <= phase_w'(1);
          if (pad_count != '1) begin
            pad_count <= pad_count + 16'd1;
          end
        end else
`endif
        if (phase == last_phase) begin
          out_valid <= 1'b1;
          out_data  <= merged_data;
          out_ctrl  <= merged_ctrl;
          phase     <= '0;
        end else begin
          acc_data <= merged_data;
          acc_ctrl <= merged_ctrl;
          phase    <= phase + phase_w'(1);
        end
      end
    end
  end

  assign bus.o_xgmii_valid   = out_valid;
  assign bus.o_xgmii_data    = out_data;
  assign bus.o_xgmii_control = out_ctrl;
endmodule

// File: tb/tb_usxgmii_width_gearbox.sv
// Scoreboard bench for usxgmii_width_gearbox: a default instance (4 bytes x2)
// and a p_ratio=4 instance. Expected output words, with the negedge on which
// they must appear, are queued when stimulus is driven; the monitor pops them.
module tb_usxgmii_width_gearbox;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned ncnt   = 0;

  localparam logic [31:0] idle32 = 32'h07070707;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  ctrl;
    int unsigned  due;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea;
  exp_t eb;
  logic [63:0] last_a;

  usxgmii_width_gearbox_if #(.p_in_bytes(4), .p_ratio(2)) bus_a ();
  usxgmii_width_gearbox_if #(.p_in_bytes(4), .p_ratio(4)) bus_b ();

  usxgmii_width_gearbox #(.p_in_bytes(4), .p_ratio(2)) dut_a (
    .i_clock (clk),
    .i_reset (rst_a),
    .bus     (bus_a)
  );

  usxgmii_width_gearbox #(.p_in_bytes(4), .p_ratio(4)) dut_b (
    .i_clock (clk),
    .i_reset (rst_b),
    .bus     (bus_b)
  );

  // Monitor: every output pulse must match the head of its queue, on time.
  always @(negedge clk) begin
    ncnt++;
    if (bus_a.o_xgmii_valid === 1'b1) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_word: got data=%h ctrl=%h at cyc %0d, required no output",
                 bus_a.o_xgmii_data, bus_a.o_xgmii_control, ncnt);
      end else begin
        ea = q_a.pop_front();
        if (128'(bus_a.o_xgmii_data) !== ea.data || 16'(bus_a.o_xgmii_control) !== ea.ctrl
            || ncnt !== ea.due) begin
          errors++;
          $display("FAIL a_word: got data=%h ctrl=%h cyc=%0d, required data=%h ctrl=%h cyc=%0d",
                   bus_a.o_xgmii_data, bus_a.o_xgmii_control, ncnt, ea.data, ea.ctrl, ea.due);
        end
      end
    end
    if (bus_b.o_xgmii_valid === 1'b1) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_word: got data=%h ctrl=%h at cyc %0d, required no output",
                 bus_b.o_xgmii_data, bus_b.o_xgmii_control, ncnt);
      end else begin
        eb = q_b.pop_front();
        if (128'(bus_b.o_xgmii_data) !== eb.data || 16'(bus_b.o_xgmii_control) !== eb.ctrl
            || ncnt !== eb.due) begin
          errors++;
          $display("FAIL b_word: got data=%h ctrl=%h cyc=%0d, required data=%h ctrl=%h cyc=%0d",
                   bus_b.o_xgmii_data, bus_b.o_xgmii_control, ncnt, eb.data, eb.ctrl, eb.due);
        end
      end
    end
  end

  task automatic drive_a(input logic v, input logic [31:0] d, input logic [3:0] c);
    @(posedge clk); #1;
    bus_a.i_usxgmii_valid   = v;
    bus_a.i_usxgmii_data    = d;
    bus_a.i_usxgmii_control = c;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] d, input logic [3:0] c);
    @(posedge clk); #1;
    bus_b.i_usxgmii_valid   = v;
    bus_b.i_usxgmii_data    = d;
    bus_b.i_usxgmii_control = c;
  endtask

  // Word driven in this cycle is accepted at the next posedge and shows up
  // on the negedge after that.
  task automatic push_a(input logic [63:0] d, input logic [7:0] c);
    q_a.push_back('{data: 128'(d), ctrl: 16'(c), due: ncnt + 2});
  endtask

  task automatic push_b(input logic [127:0] d, input logic [15:0] c);
    q_b.push_back('{data: d, ctrl: c, due: ncnt + 2});
  endtask

  task automatic drain;
    for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) @(posedge clk);
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d words still pending, required 0/0", q_a.size(), q_b.size());
      q_a.delete();
      q_b.delete();
    end
  endtask

  task automatic reset_a;
    @(posedge clk); #1;
    rst_a = 1'b1;
    bus_a.i_usxgmii_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b0;
  endtask

  task automatic check_pad_a(input logic [15:0] want, input string name);
    checks++;
    if (bus_a.o_pad_count !== want) begin
      errors++;
      $display("FAIL %s: got pad_count=%h, required %h", name, bus_a.o_pad_count, want);
    end
  endtask

  task automatic test_reset;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.i_usxgmii_valid = 1'b1; bus_a.i_usxgmii_data = 32'h12345678; bus_a.i_usxgmii_control = 4'h2;
    bus_b.i_usxgmii_valid = 1'b1; bus_b.i_usxgmii_data = 32'h9ABCDEF0; bus_b.i_usxgmii_control = 4'h4;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (bus_a.o_xgmii_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid: got %b, required 0", bus_a.o_xgmii_valid); end
    if (bus_a.o_xgmii_data !== {idle32, idle32}) begin errors++; $display("FAIL reset_a_data: got %h, required idle", bus_a.o_xgmii_data); end
    if (bus_a.o_xgmii_control !== 8'hFF) begin errors++; $display("FAIL reset_a_ctrl: got %h, required ff", bus_a.o_xgmii_control); end
    if (bus_a.o_pad_count !== 16'h0) begin errors++; $display("FAIL reset_a_pad: got %h, required 0", bus_a.o_pad_count); end
    checks += 4;
    if (bus_b.o_xgmii_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid: got %b, required 0", bus_b.o_xgmii_valid); end
    if (bus_b.o_xgmii_data !== {4{idle32}}) begin errors++; $display("FAIL reset_b_data: got %h, required idle", bus_b.o_xgmii_data); end
    if (bus_b.o_xgmii_control !== 16'hFFFF) begin errors++; $display("FAIL reset_b_ctrl: got %h, required ffff", bus_b.o_xgmii_control); end
    if (bus_b.o_pad_count !== 16'h0) begin errors++; $display("FAIL reset_b_pad: got %h, required 0", bus_b.o_pad_count); end
    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.i_usxgmii_valid = 1'b0;
    bus_b.i_usxgmii_valid = 1'b0;
  endtask

  task automatic test_pack;
    logic [31:0] w [4];
    logic [3:0]  c [4];
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      c[i] = 4'(2 * (i + 1));
    end
    drive_a(1'b1, w[0], c[0]);
    drive_a(1'b1, w[1], c[1]);
    push_a({w[1], w[0]}, {c[1], c[0]});
    drive_a(1'b1, w[2], c[2]);
    drive_a(1'b1, w[3], c[3]);
    push_a({w[3], w[2]}, {c[3], c[2]});
    last_a = {w[3], w[2]};
    drive_a(1'b0, 32'h0, 4'h0);
    drain();
    check_pad_a(16'h0, "pack_pad");
  endtask

  task automatic test_bubbles;
    logic [31:0] a0, a1;
    a0 = $urandom;
    a1 = $urandom;
    drive_a(1'b1, a0, 4'h4);
    repeat (3) drive_a(1'b0, $urandom, 4'hF);
    checks++;
    if (bus_a.o_xgmii_data !== last_a) begin
      errors++;
      $display("FAIL bubble_hold: got data=%h, required %h", bus_a.o_xgmii_data, last_a);
    end
    drive_a(1'b1, a1, 4'h8);
    push_a({a1, a0}, {4'h8, 4'h4});
    drive_a(1'b0, 32'h0, 4'h0);
    drain();
  endtask

  task automatic test_start;
    logic [31:0] a0, s, a2;
    a0 = $urandom;
    s  = {24'hC0FFEE, 8'hFB};
    a2 = $urandom;
    drive_a(1'b1, a0, 4'h0);
    drive_a(1'b1, s, 4'h1);
`ifdef USXGMII_GEARBOX_START_ALIGN_EN
    push_a({idle32, a0}, 8'hF0);
    drive_a(1'b1, a2, 4'h2);
    push_a({a2, s}, {4'h2, 4'h1});
    drive_a(1'b0, 32'h0, 4'h0);
    drain();
    check_pad_a(16'h1, "start_pad");
`else
    push_a({s, a0}, {4'h1, 4'h0});
    drive_a(1'b1, a2, 4'h2);
    drive_a(1'b0, 32'h0, 4'h0);
    drain();
    check_pad_a(16'h0, "start_pad");
`endif
    reset_a();
  endtask

  task automatic test_aligned_start;
    logic [31:0] s, a1;
    s  = {24'h55AA33, 8'hFB};
    a1 = $urandom;
    drive_a(1'b1, s, 4'h1);
    drive_a(1'b1, a1, 4'h6);
    push_a({a1, s}, {4'h6, 4'h1});
    drive_a(1'b0, 32'h0, 4'h0);
    drain();
    check_pad_a(16'h0, "aligned_start_pad");
  endtask

  task automatic test_back_to_back;
    logic [31:0] prev_d, d;
    logic [3:0]  prev_c, c;
    prev_d = '0;
    prev_c = '0;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      c = 4'($urandom) & 4'hE;
      drive_a(1'b1, d, c);
      if (i % 2 == 1) push_a({d, prev_d}, {c, prev_c});
      prev_d = d;
      prev_c = c;
    end
    drive_a(1'b0, 32'h0, 4'h0);
    drain();
  endtask

`ifdef USXGMII_GEARBOX_START_ALIGN_EN
  task automatic test_saturate;
    logic [31:0] a0, s, a2;
    a0 = $urandom;
    s  = {24'h010203, 8'hFB};
    a2 = $urandom;
    reset_a();
    force dut_a.pad_count = 16'hFFFF;
    @(posedge clk);
    release dut_a.pad_count;
    drive_a(1'b1, a0, 4'h8);
    drive_a(1'b1, s, 4'h1);
    push_a({idle32, a0}, 8'hF8);
    drive_a(1'b1, a2, 4'h0);
    push_a({a2, s}, {4'h0, 4'h1});
    drive_a(1'b0, 32'h0, 4'h0);
    drain();
    check_pad_a(16'hFFFF, "saturate_pad");
  endtask
`endif

  task automatic test_reset_mid;
    logic [31:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = $urandom;
    drive_b(1'b1, $urandom, 4'h2);
    drive_b(1'b1, $urandom, 4'h4);
    @(posedge clk); #1;
    rst_b = 1'b1;
    bus_b.i_usxgmii_valid = 1'b1;
    bus_b.i_usxgmii_data = 32'hDEADBEEF;
    bus_b.i_usxgmii_control = 4'h8;
    @(posedge clk); #1;
    checks += 4;
    if (bus_b.o_xgmii_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b, required 0", bus_b.o_xgmii_valid); end
    if (bus_b.o_xgmii_data !== {4{idle32}}) begin errors++; $display("FAIL mid_reset_data: got %h, required idle", bus_b.o_xgmii_data); end
    if (bus_b.o_xgmii_control !== 16'hFFFF) begin errors++; $display("FAIL mid_reset_ctrl: got %h, required ffff", bus_b.o_xgmii_control); end
    if (bus_b.o_pad_count !== 16'h0) begin errors++; $display("FAIL mid_reset_pad: got %h, required 0", bus_b.o_pad_count); end
    @(posedge clk); #1;
    rst_b = 1'b0;
    bus_b.i_usxgmii_valid = 1'b0;
    drive_b(1'b1, b[0], 4'h2);
    drive_b(1'b1, b[1], 4'h4);
    drive_b(1'b1, b[2], 4'h8);
    drive_b(1'b1, b[3], 4'hA);
    push_b({b[3], b[2], b[1], b[0]}, 16'hA842);
    drive_b(1'b0, 32'h0, 4'h0);
    drain();
  endtask

  initial begin
    bus_a.i_usxgmii_valid = 1'b0;
    bus_a.i_usxgmii_data = '0;
    bus_a.i_usxgmii_control = '0;
    bus_b.i_usxgmii_valid = 1'b0;
    bus_b.i_usxgmii_data = '0;
    bus_b.i_usxgmii_control = '0;
    test_reset();
    test_pack();
    test_bubbles();
    test_start();
    test_aligned_start();
    test_back_to_back();
`ifdef USXGMII_GEARBOX_START_ALIGN_EN
    test_saturate();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion after 200000 time units, required completion");
    $fatal(1, "bench timeout");
  end
endmodule

// File: doc/usxgmii_width_gearbox.md
USXGMII_WIDTH_GEARBOX -- requirements
Module: usxgmii_width_gearbox

Interface
REQ-001 Parameter p_in_bytes, default 4, SHALL set the byte lanes per input word; legal values are 4 and 8.
REQ-002 Parameter p_ratio, default 2, SHALL set the input words packed per output word; legal values are 2 and 4.
REQ-003 i_clock  input  1  SHALL be the single clock; all logic is rising-edge, and there is no second clock domain.
REQ-004 i_reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 i_usxgmii_valid  input  1  SHALL qualify the input word for the current cycle.
REQ-006 i_usxgmii_control  input  p_in_bytes  SHALL carry per-lane control flags.
REQ-007 i_usxgmii_data  input  8*p_in_bytes  SHALL carry lane data, with lane 0 in the LSBs.
REQ-008 o_xgmii_valid  output  1  SHALL mark a completed output word for exactly one cycle.
REQ-009 o_xgmii_control  output  p_in_bytes*p_ratio  SHALL carry the packed control flags.
REQ-010 o_xgmii_data  output  8*p_in_bytes*p_ratio  SHALL carry the packed data.
REQ-011 o_pad_count  output  16  SHALL count alignment pads and saturate at 0xFFFF.

Function
REQ-012 A slot phase counter SHALL run 0..p_ratio-1 and advance only on cycles where i_usxgmii_valid=1.
REQ-013 An accepted word at phase k SHALL be stored in output slot k at bits [k*8*p_in_bytes +: 8*p_in_bytes]; its control flags SHALL be stored at the matching control bits.
REQ-014 Accepting a word at phase p_ratio-1 SHALL drive o_xgmii_valid=1 on the next cycle with all slots, and SHALL return the phase to 0.
REQ-015 Latency SHALL be exactly 1 cycle from the final slot's accept to o_xgmii_valid.
REQ-016 Input bubbles (i_usxgmii_valid=0) SHALL hold the phase and the partial contents with no timeout.
REQ-017 o_xgmii_data/o_xgmii_control SHALL hold their last value while o_xgmii_valid=0.
REQ-018 Back-to-back full words SHALL be sustainable with no input throttling; the block has no backpressure output.
REQ-019 A start character is lane 0 data 0xFB with lane 0 control=1.
REQ-020 With alignment compiled in, a start word accepted at phase k!=0 SHALL:
- fill slots k..p_ratio-1 with Idle (data 0x07, control 1 per lane);
- assert o_xgmii_valid on the next cycle with that padded word;
- store the start word in slot 0 and set phase=1;
- increment o_pad_count by 1, saturating.
REQ-021 A start word accepted at phase 0 SHALL be packed normally and SHALL NOT increment o_pad_count.
REQ-022 In both the normal path (REQ-014) and the pad path (REQ-020), o_xgmii_valid SHALL pulse for exactly one cycle per output word, never two words in one cycle.
REQ-023 A start word arriving while p_ratio=2 and phase=1 SHALL produce the pad word, followed by normal packing from phase 1.

Reset
REQ-024 While i_reset=1, the block SHALL drive:
- o_xgmii_valid=0;
- o_xgmii_data=Idle pattern (0x07 in every byte);
- o_xgmii_control=all ones;
- o_pad_count=0;
- phase=0.
REQ-025 Reset asserted mid-word SHALL discard partial slots; the first accepted word after deassert SHALL go to slot 0.
REQ-026 Input accepted in a cycle where i_reset=1 SHALL be ignored.

Configuration
REQ-027 Macro USXGMII_GEARBOX_START_ALIGN_EN SHALL compile in the REQ-020 alignment logic and the o_pad_count counter.
REQ-028 Without USXGMII_GEARBOX_START_ALIGN_EN, start words SHALL pack with no special handling, and o_pad_count SHALL be tied to 0; the port list SHALL be unchanged.

Verification
REQ-029 Defaults; words A0..A3 continuously valid -> o_xgmii_valid at cycles 2 and 4; data={A1,A0}, then {A3,A2}; o_pad_count=0.
REQ-030 Defaults; A0, three bubbles, A1 -> one output {A1,A0}, 1 cycle after A1 is accepted; o_xgmii_valid stays 0 during the bubbles.
REQ-031 Align enabled; A0, then S=0x..FB/ctrl 0x1, then A2 -> outputs {Idle,A0} with control 0xF0, then {A2,S}; o_pad_count=1.
REQ-032 Align disabled; the same stimulus as REQ-031 -> outputs {S,A0} only; o_pad_count=0.
REQ-033 p_ratio=4; A0, A1, reset pulse, B0..B3 -> the only output is {B3,B2,B1,B0}; during reset, outputs equal the REQ-024 values.
REQ-034 Align enabled; o_pad_count forced to 0xFFFF, then a misaligned start -> the count stays 0xFFFF and the pad word is still emitted.
